// File: rtl/param_fifo.sv
// param_fifo: single-clock synchronous FIFO with level/threshold flags and
// sticky error flags. Two read modes:
//   FWFT=1 : head word is presented combinationally on pop_data whenever the
//            FIFO is non-empty; rd_valid mirrors not_empty.
//   FWFT=0 : pop_data is registered; it loads the head word on an accepted
//            pop and rd_valid pulses for the following cycle only.
// Ports:
//   aclk, areset      clock, synchronous active-high reset
//   push_data, push   write data / write request
//   pop               read request
//   err_clr           clears overflow/underflow
//   pop_data,rd_valid read data and its qualifier
//   not_empty, full, almost_full, almost_empty, level   occupancy status
//   overflow, underflow  sticky error flags
module param_fifo #(
  parameter int DWIDTH    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [DWIDTH-1:0]        push_data,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     err_clr,
  output logic [DWIDTH-1:0]        pop_data,
  output logic                     rd_valid,
  output logic                     not_empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Status flags decode the level register only, so they never form a
  // combinational path from push/pop.
  assign not_empty    = (level != '0);
  assign full         = (level == LW'(DEPTH));
  assign almost_full  = (level >= LW'(AF_THRESH));
  assign almost_empty = (level <= LW'(AE_THRESH));

  // Full blocks push even when a pop happens in the same cycle; empty blocks
  // pop even when a push happens in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & not_empty;

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is the natural AW-bit rollover.
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // A new error event wins over a simultaneous clear.
      overflow  <= (push & full)       | (overflow  & ~err_clr);
      underflow <= (pop  & ~not_empty) | (underflow & ~err_clr);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge aclk) begin
    if (!areset && push_ok) mem[wr_ptr] <= push_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Gated to zero while empty so the output is clean right after reset.
      assign pop_data = not_empty ? mem[rd_ptr] : '0;
      assign rd_valid = not_empty;
    end else begin : g_reg
      always_ff @(posedge aclk) begin
        if (areset) begin
          pop_data <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= pop_ok;
          if (pop_ok) pop_data <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: two instances (FWFT=1 with AF=6/AE=2, FWFT=0 with
// default thresholds) share one stimulus stream and are compared each cycle
// against a queue-based reference model. Directed table rows and a few
// hand-written sequences cover the corner cases.
module tb_param_fifo;

  logic        aclk = 1'b0;
  logic        areset, push, pop, err_clr;
  logic [31:0] push_data;

  logic [31:0] pd_a, pd_b;
  logic        rv_a, ne_a, fu_a, af_a, ae_a, ov_a, un_a;
  logic        rv_b, ne_b, fu_b, af_b, ae_b, ov_b, un_b;
  logic [3:0]  lv_a, lv_b;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  param_fifo #(.DWIDTH(32), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1)) dut_a (
    .aclk(aclk), .areset(areset), .push_data(push_data), .push(push), .pop(pop),
    .err_clr(err_clr), .pop_data(pd_a), .rd_valid(rv_a), .not_empty(ne_a),
    .full(fu_a), .almost_full(af_a), .almost_empty(ae_a), .level(lv_a),
    .overflow(ov_a), .underflow(un_a));

  param_fifo #(.DWIDTH(32), .DEPTH(8), .FWFT(0)) dut_b (
    .aclk(aclk), .areset(areset), .push_data(push_data), .push(push), .pop(pop),
    .err_clr(err_clr), .pop_data(pd_b), .rd_valid(rv_b), .not_empty(ne_b),
    .full(fu_b), .almost_full(af_b), .almost_empty(ae_b), .level(lv_b),
    .overflow(ov_b), .underflow(un_b));

  // Reference model: plain queue of stored words plus sticky flags and the
  // registered-read output state of the FWFT=0 instance.
  logic [31:0] q[$];
  bit          m_ovf = 0, m_unf = 0, m_bv = 0;
  logic [31:0] m_bd = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit p, input bit o, input bit c,
                            input logic [31:0] d);
    bit was_full, was_empty;
    if (r) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_bv = 0; m_bd = '0;
      return;
    end
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    m_bv = o && !was_empty;
    if (m_bv) begin
      m_bd = q[0];
      void'(q.pop_front());
    end
    if (p && !was_full) q.push_back(d);
    m_ovf = (p && was_full)  ? 1'b1 : (c ? 1'b0 : m_ovf);
    m_unf = (o && was_empty) ? 1'b1 : (c ? 1'b0 : m_unf);
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("level_a", 64'(lv_a), 64'(n));
    chk("level_b", 64'(lv_b), 64'(n));
    chk("not_empty_a", 64'(ne_a), 64'(n != 0));
    chk("not_empty_b", 64'(ne_b), 64'(n != 0));
    chk("full_a", 64'(fu_a), 64'(n == 8));
    chk("full_b", 64'(fu_b), 64'(n == 8));
    chk("almost_full_a", 64'(af_a), 64'(n >= 6));
    chk("almost_empty_a", 64'(ae_a), 64'(n <= 2));
    chk("almost_full_b", 64'(af_b), 64'(n >= 7));
    chk("almost_empty_b", 64'(ae_b), 64'(n <= 1));
    chk("overflow_a", 64'(ov_a), 64'(m_ovf));
    chk("overflow_b", 64'(ov_b), 64'(m_ovf));
    chk("underflow_a", 64'(un_a), 64'(m_unf));
    chk("underflow_b", 64'(un_b), 64'(m_unf));
    chk("rd_valid_a", 64'(rv_a), 64'(n != 0));
    if (n != 0) chk("pop_data_a", 64'(pd_a), 64'(q[0]));
    chk("rd_valid_b", 64'(rv_b), 64'(m_bv));
    chk("pop_data_b", 64'(pd_b), 64'(m_bd));
  endtask

  // Inputs change just after the falling edge; outputs are checked at the
  // next falling edge, well away from the active rising edge.
  task automatic cycle(input bit r, input bit p, input bit o, input bit c,
                       input logic [31:0] d);
    areset = r; push = p; pop = o; err_clr = c; push_data = d;
    @(posedge aclk);
    model_step(r, p, o, c, d);
    @(negedge aclk);
    check_model();
  endtask

  typedef struct {
    bit          rst, psh, pp, clr;
    logic [31:0] din;
    int          lvl;
    bit          ovf, unf;
    logic [31:0] head;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit p, bit o, bit c, logic [31:0] d,
                              int l, bit ov, bit un, logic [31:0] h);
    vec_t v;
    v.rst = r; v.psh = p; v.pp = o; v.clr = c; v.din = d;
    v.lvl = l; v.ovf = ov; v.unf = un; v.head = h;
    return v;
  endfunction

  initial begin
    areset = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = '0;

    // Directed table: fill, push+pop while full, drain, empty-side errors.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(0, 1, 0, 0, 32'(i), i, 0, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 9, 7, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 7, 0, 0, 2));
    for (int k = 1; k <= 7; k++) tbl.push_back(mk(0, 0, 1, 0, 0, 7 - k, 0, 0, 32'(k + 2)));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 32'h55, 1, 0, 1, 32'h55));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0));

    @(negedge aclk);
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].psh, tbl[i].pp, tbl[i].clr, tbl[i].din);
      chk($sformatf("tbl%0d_level", i), 64'(lv_a), 64'(tbl[i].lvl));
      chk($sformatf("tbl%0d_ovf", i), 64'(ov_a), 64'(tbl[i].ovf));
      chk($sformatf("tbl%0d_unf", i), 64'(un_a), 64'(tbl[i].unf));
      if (tbl[i].lvl > 0) chk($sformatf("tbl%0d_head", i), 64'(pd_a), 64'(tbl[i].head));
    end

    // Registered read: data and valid arrive exactly one cycle after the pop.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 32'hA5);
    cycle(0, 0, 1, 0, 0);
    chk("fwft0_rd_valid", 64'(rv_b), 64'd1);
    chk("fwft0_pop_data", 64'(pd_b), 64'hA5);
    cycle(0, 0, 0, 0, 0);
    chk("fwft0_rd_valid_drop", 64'(rv_b), 64'd0);
    chk("fwft0_pop_data_hold", 64'(pd_b), 64'hA5);

    // Threshold sweep 0..8 on the AF=6/AE=2 instance.
    cycle(1, 0, 0, 0, 0);
    chk("thr_ae_l0", 64'(ae_a), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, 0, 0, 32'h100 + 32'(i));
      chk($sformatf("thr_ae_l%0d", i), 64'(ae_a), 64'(i <= 2));
      chk($sformatf("thr_af_l%0d", i), 64'(af_a), 64'(i >= 6));
    end

    // 20 pushes interleaved with 20 pops through pointer wrap, then reset at level 3.
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 1, (i >= 3), 0, 32'hC000 + 32'(i));
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 32'hD000 + 32'(i));
    chk("pre_rst_level", 64'(lv_a), 64'd3);
    cycle(1, 1, 1, 0, 32'hDEAD);
    chk("post_rst_level_a", 64'(lv_a), 64'd0);
    chk("post_rst_level_b", 64'(lv_b), 64'd0);
    chk("post_rst_pop_data_a", 64'(pd_a), 64'd0);
    chk("post_rst_pop_data_b", 64'(pd_b), 64'd0);
    chk("post_rst_not_empty", 64'(ne_a), 64'd0);

    // Randomized traffic: push-heavy, then pop-heavy, then balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 200; i++) begin
        int pp, op;
        pp = (ph == 0) ? 75 : (ph == 1) ? 30 : 50;
        op = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
        cycle(($urandom_range(0, 99) < 1),
              ($urandom_range(0, 99) < pp),
              ($urandom_range(0, 99) < op),
              ($urandom_range(0, 99) < 5),
              $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
